jtag_cmd_reg: RTL and testbench
===============================

Name: jtag_cmd_reg

Overview:
- User data register that sits directly downstream of the JTAG TAP primitive wrapper.
- Shifts a command word in on TDI and a status/read-data word out on TDO.
- On UPDATE, decodes the word into a single-outstanding read or write request toward the memory/CDC stage.
- Clocked by the TAP data-register clock (DRCK), so the block is single-domain.

Parameters:
- DATA_W, 32, data width of requests and read responses.
- ADDR_W, 16, address width; must be >= 2.
- TIMEOUT, 1023, cycles a request may stay busy before abort (used only with the optional feature).
- Derived: L = 2 + ADDR_W + DATA_W = DR length, 50 with the defaults.

Ports:
- clk  in  1  TAP DR clock (DRCK).
- reset  in  1  asynchronous, active-high reset.
- treset  in  1  TAP test-logic-reset; synchronous clear.
- sel  in  1  this chain's user instruction is selected.
- capture  in  1  TAP Capture-DR.
- shift  in  1  TAP Shift-DR.
- update  in  1  TAP Update-DR.
- tdi  in  1  serial in.
- tdo  out  1  serial out.
- req_valid  out  1  request valid.
- req_ready  in  1  request accepted when high together with req_valid.
- req_we  out  1  1 = write, 0 = read.
- req_addr  out  ADDR_W  request address.
- req_wdata  out  DATA_W  write data.
- rsp_valid  in  1  read data valid, single-cycle pulse.
- rsp_rdata  in  DATA_W  read data.

Behaviour:
- Reset values (reset or treset): sr=0, tdo=0, req_valid=0, req_we=0, req_addr=0, req_wdata=0, busy=0, rd_valid=0, overrun=0, rdata=0, timeout=0. reset is asynchronous; treset clears synchronously with the same effect.
- tdo = sr[0], combinational.
- When sel=0: capture, shift and update are ignored. The request/response side keeps running.
- Priority when strobes are simultaneous: capture > shift > update.
- Capture: sr loads rdata in [DATA_W-1:0], busy at DATA_W, rd_valid at DATA_W+1, overrun at DATA_W+2, timeout at DATA_W+3; all other bits are 0. rd_valid clears in the same cycle (read-to-clear).
- Shift: sr <= {tdi, sr[L-1:1]}, LSB goes out first.
- Update: fields are cmd = sr[L-1:L-2], addr = sr[DATA_W +: ADDR_W], data = sr[DATA_W-1:0].
  - 00 NOP: no effect.
  - 01 READ: if idle, register the request with req_we=0.
  - 10 WRITE: if idle, register the request with req_we=1 and req_wdata=data.
  - 11 CLEAR: clears overrun, rd_valid and timeout. CLEAR does not affect busy.
- READ or WRITE received while busy=1: command dropped, overrun set (sticky). busy is sampled at the start of the cycle, so a req_ready retiring the current request in the same cycle still causes overrun.
- FSM IDLE -> REQ -> (WAIT_RSP) -> IDLE:
  - IDLE: on an accepted command, go to REQ next cycle with req_valid=1 and busy=1.
  - REQ: req_valid and the request fields are held stable until req_valid & req_ready. A write then goes to IDLE with busy=0. A read goes to WAIT_RSP with req_valid=0.
  - WAIT_RSP: on rsp_valid, rdata <= rsp_rdata, rd_valid=1, busy=0, go to IDLE.
- rsp_valid outside WAIT_RSP is ignored.
- Latency: req_valid rises 1 cycle after the update cycle.

Optional Feature:
- Macro: JTAG_CMD_TIMEOUT_EN.
- Defined: a counter clears on entry to REQ and increments every cycle while in REQ or WAIT_RSP. When it reaches TIMEOUT: req_valid=0, busy=0, timeout set (sticky, cleared by CLEAR or reset), go to IDLE. A late rsp_valid after the abort is ignored.
- Undefined: no counter, capture bit DATA_W+3 reads 0, and a request can stay busy indefinitely.

Test Plan:
- WRITE: shift 50 bits (cmd=10, addr=0x1234, data=0xDEADBEEF), then update, with req_ready=1 -> req_valid is high for exactly 1 cycle with req_we=1, req_addr=0x1234, req_wdata=0xDEADBEEF. A following capture/shift shows busy=0 and overrun=0.
- READ: cmd=01, addr=0x0040; hold req_ready=0 for 5 cycles, then 1; rsp_valid pulses 3 cycles later with 0xCAFEF00D -> req_valid stays stable for 6 cycles. The next capture shifts out 0xCAFEF00D LSB-first followed by busy=0 and rd_valid=1. A second capture shows rd_valid=0.
- Overrun: a READ is pending with no req_ready, then a WRITE is updated -> no second request is issued and capture bit 34 = 1. CLEAR then clears it to 0.
- sel=0: shift and update a WRITE -> sr is unchanged and req_valid stays 0.
- Reset mid-operation: assert reset while in REQ -> req_valid drops immediately (asynchronously) and all status bits read 0. Repeat with treset -> outputs clear on the next edge.
- With JTAG_CMD_TIMEOUT_EN and TIMEOUT=8: a READ with req_ready=0 -> req_valid drops after 8 cycles and capture bit 35 = 1. Without the macro, req_valid remains high.

Source files
------------

// File: rtl/jtag_cmd_reg_if.sv
// Request/response bus between the JTAG command register and the memory/CDC stage.
// master = command register side, slave = memory side.
interface jtag_cmd_reg_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/jtag_cmd_reg.sv
// JTAG user DR: shifts in {cmd,addr,data}, issues one outstanding read/write, captures status.
// Optional request abort after TIMEOUT cycles when JTAG_CMD_TIMEOUT_EN is defined.
module jtag_cmd_reg #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic treset,
  input  logic sel,
  input  logic capture,
  input  logic shift,
  input  logic update,
  input  logic tdi,
  output logic tdo,
  jtag_cmd_reg_if.master mem
);
  localparam int L = 2 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_e;

  state_e            state_q;
  logic [L-1:0]      sr_q;
  logic              req_valid_q, req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q, rdata_q;
  logic              busy_q, rd_valid_q, overrun_q, timeout_q;
`ifdef JTAG_CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_hit;
  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  logic         cap_v, shf_v, upd_v;
  logic [1:0]   cmd;
  logic [L-1:0] cap_word;

  assign cap_v = sel & capture;
  assign shf_v = sel & shift & ~capture;
  assign upd_v = sel & update & ~capture & ~shift;
  assign cmd   = sr_q[L-1 -: 2];
  assign tdo   = sr_q[0];

  always_comb begin
    cap_word             = '0;
    cap_word[DATA_W-1:0] = rdata_q;
    cap_word[DATA_W]     = busy_q;
    cap_word[DATA_W+1]   = rd_valid_q;
    cap_word[DATA_W+2]   = overrun_q;
    cap_word[DATA_W+3]   = timeout_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef JTAG_CMD_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else if (treset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef JTAG_CMD_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      // TAP side; busy_q is the start-of-cycle value, so a same-cycle retire still overruns
      if (cap_v) begin
        sr_q       <= cap_word;
        rd_valid_q <= 1'b0;
      end else if (shf_v) begin
        sr_q <= {tdi, sr_q[L-1:1]};
      end else if (upd_v) begin
        case (cmd)
          2'b01, 2'b10: begin
            if (busy_q) begin
              overrun_q <= 1'b1;
            end else begin
              req_we_q    <= cmd[1];
              req_addr_q  <= sr_q[DATA_W +: ADDR_W];
              if (cmd[1]) req_wdata_q <= sr_q[DATA_W-1:0];
              req_valid_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= REQ;
`ifdef JTAG_CMD_TIMEOUT_EN
              cnt_q       <= '0;
`endif
            end
          end
          2'b11: begin
            overrun_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
          end
          default: ;
        endcase
      end

      // Request side runs regardless of sel; placed last so a response wins over capture's clear
      case (state_q)
        REQ: begin
          if (req_valid_q && mem.req_ready) begin
            req_valid_q <= 1'b0;
            if (req_we_q) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT_RSP;
            end
          end
`ifdef JTAG_CMD_TIMEOUT_EN
          else if (tmo_hit) begin
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b1;
            state_q     <= IDLE;
          end
          if (!tmo_hit) cnt_q <= cnt_q + 1'b1;
`endif
        end
        WAIT_RSP: begin
          if (mem.rsp_valid) begin
            rdata_q    <= mem.rsp_rdata;
            rd_valid_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
`ifdef JTAG_CMD_TIMEOUT_EN
          else if (tmo_hit) begin
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end
          if (!tmo_hit) cnt_q <= cnt_q + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign mem.req_valid = req_valid_q;
  assign mem.req_we    = req_we_q;
  assign mem.req_addr  = req_addr_q;
  assign mem.req_wdata = req_wdata_q;
endmodule

// File: tb/tb_jtag_cmd_reg.sv
// Directed + randomized bench for jtag_cmd_reg against a transaction-level status model.
module tb_jtag_cmd_reg;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int TMO = 8;
  localparam int L   = 2 + AW + DW;

  logic clk = 1'b0, reset, treset, sel, capture, shift, update, tdi, tdo;
  int total = 0, bad = 0;

  jtag_cmd_reg_if #(.DATA_W(DW), .ADDR_W(AW)) mem ();

  jtag_cmd_reg #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .treset(treset), .sel(sel), .capture(capture),
    .shift(shift), .update(update), .tdi(tdi), .tdo(tdo), .mem(mem)
  );

  always #5 clk = ~clk;

  // Reference model: status as seen through capture
  logic          m_busy, m_rdv, m_ovr, m_tmo;
  logic [DW-1:0] m_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [L-1:0] mk(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {c, a, d};
  endfunction

  function automatic logic [L-1:0] exp_status();
    logic [L-1:0] s;
    s = '0;
    s[DW-1:0] = m_rdata;
    s[DW]     = m_busy;
    s[DW+1]   = m_rdv;
    s[DW+2]   = m_ovr;
    s[DW+3]   = m_tmo;
    return s;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_rdv = 0; m_ovr = 0; m_tmo = 0; m_rdata = '0;
  endtask

  task automatic shift_in(input logic [L-1:0] w);
    shift = 1;
    for (int i = 0; i < L; i++) begin
      tdi = w[i];
      cyc();
    end
    shift = 0; tdi = 0;
  endtask

  task automatic do_update();
    update = 1; cyc(); update = 0;
  endtask

  task automatic shift_out(output logic [L-1:0] w);
    shift = 1; tdi = 0;
    for (int i = 0; i < L; i++) begin
      w[i] = tdo;
      cyc();
    end
    shift = 0;
  endtask

  task automatic cap_chk(input string tag);
    logic [L-1:0] w;
    capture = 1; cyc(); capture = 0;
    shift_out(w);
    chk(tag, 64'(w), 64'(exp_status()));
    m_rdv = 0;
  endtask

  // Issue a request, stall req_ready for dly cycles, then answer reads after lat cycles.
  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int dly, input int lat, input logic [DW-1:0] rd);
    shift_in(mk(we ? 2'b10 : 2'b01, a, d));
    do_update();
    for (int k = 0; k <= dly; k++) begin
      chk("req_hold", {mem.req_valid, mem.req_we, mem.req_addr}, {1'b1, we, a});
      if (we) chk("req_wdata", 64'(mem.req_wdata), 64'(d));
      if (k == dly) mem.req_ready = 1;
      cyc();
      mem.req_ready = 0;
    end
    chk("req_drop", 64'(mem.req_valid), 64'd0);
    if (!we) begin
      repeat (lat) cyc();
      mem.rsp_valid = 1; mem.rsp_rdata = rd;
      cyc();
      mem.rsp_valid = 0;
      m_rdata = rd; m_rdv = 1;
    end
  endtask

  initial begin
    logic [L-1:0] pat, w;
    logic [1:0]   op;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    reset = 1; treset = 0; sel = 1; capture = 0; shift = 0; update = 0; tdi = 0;
    mem.req_ready = 0; mem.rsp_valid = 0; mem.rsp_rdata = '0;
    model_clear();
    repeat (3) cyc();
    chk("rst_outs", {tdo, mem.req_valid, mem.req_we, mem.req_addr, mem.req_wdata}, '0);
    reset = 0;
    cyc();
    cap_chk("rst_cap");

    // Directed write with req_ready already high: one-cycle req_valid
    mem.req_ready = 1;
    shift_in(mk(2'b10, 16'h1234, 32'hDEADBEEF));
    do_update();
    chk("wr_req", {mem.req_valid, mem.req_we, mem.req_addr, mem.req_wdata},
        {1'b1, 1'b1, 16'h1234, 32'hDEADBEEF});
    cyc();
    chk("wr_1cyc", 64'(mem.req_valid), 64'd0);
    mem.req_ready = 0;
    cap_chk("wr_cap");

    // Directed read, 6-cycle stall, then read-to-clear
    do_req(1'b0, 16'h0040, '0, 5, 3, 32'hCAFEF00D);
    cap_chk("rd_cap");
    cap_chk("rd_cap2");

    // Randomized command stream
    for (int it = 0; it < 24; it++) begin
      op = 2'($urandom_range(0, 3));
      a  = 16'($urandom);
      d  = $urandom;
      case (op)
        2'b01:   do_req(1'b0, a, d, $urandom_range(0, 4), $urandom_range(0, 3), $urandom);
        2'b10:   do_req(1'b1, a, d, $urandom_range(0, 4), 0, '0);
        2'b11:   begin shift_in(mk(2'b11, a, d)); do_update(); m_ovr = 0; m_rdv = 0; m_tmo = 0; end
        default: begin
          shift_in(mk(2'b00, a, d)); do_update();
          chk("nop_idle", 64'(mem.req_valid), 64'd0);
        end
      endcase
      if ($urandom_range(0, 1) == 1) cap_chk("rnd_cap");
    end
    cap_chk("rnd_end");

    // Overrun: write arrives while a read is stalled
    shift_in(mk(2'b01, 16'h0101, '0));
    do_update();
    shift_in(mk(2'b10, 16'h0202, 32'h11111111));
    do_update();
    m_ovr = 1;
    chk("ovr_hold", {mem.req_valid, mem.req_we, mem.req_addr}, {1'b1, 1'b0, 16'h0101});
    mem.req_ready = 1; cyc(); mem.req_ready = 0;
    chk("ovr_single", 64'(mem.req_valid), 64'd0);
    mem.rsp_valid = 1; mem.rsp_rdata = 32'h0BADF00D; cyc(); mem.rsp_valid = 0;
    m_rdata = 32'h0BADF00D; m_rdv = 1;
    repeat (2) cyc();
    chk("ovr_noreq", 64'(mem.req_valid), 64'd0);
    cap_chk("ovr_cap");
    shift_in(mk(2'b11, '0, '0)); do_update();
    m_ovr = 0; m_rdv = 0; m_tmo = 0;
    cap_chk("clr_cap");

    // sel=0 ignores shift/update; sr keeps a preloaded pattern
    pat = mk(2'b00, 16'($urandom), $urandom);
    shift_in(pat);
    sel = 0;
    shift_in(mk(2'b10, 16'hBEEF, 32'h12345678));
    do_update();
    chk("sel0_noreq", 64'(mem.req_valid), 64'd0);
    sel = 1;
    shift_out(w);
    chk("sel0_sr", 64'(w), 64'(pat));
    chk("sel0_idle", 64'(mem.req_valid), 64'd0);

    // Async reset while in REQ
    shift_in(mk(2'b01, 16'h0077, '0)); do_update();
    chk("arst_pre", 64'(mem.req_valid), 64'd1);
    #2 reset = 1;
    #1 chk("arst_now", {mem.req_valid, tdo}, 2'b00);
    cyc(); reset = 0; cyc();
    model_clear();
    cap_chk("arst_cap");

    // Sync treset while in REQ, with nonzero rdata beforehand
    do_req(1'b0, 16'h0033, '0, 0, 1, 32'h5A5AA5A5);
    shift_in(mk(2'b10, 16'h0044, 32'h99999999)); do_update();
    treset = 1;
    #1 chk("trst_sync", 64'(mem.req_valid), 64'd1);
    cyc();
    chk("trst_edge", 64'(mem.req_valid), 64'd0);
    treset = 0;
    model_clear();
    cap_chk("trst_cap");

    // Stalled read: aborts after TMO cycles only when the timeout feature is built in
    shift_in(mk(2'b01, 16'h0555, '0)); do_update();
`ifdef JTAG_CMD_TIMEOUT_EN
    for (int k = 0; k < TMO; k++) begin
      chk("tmo_high", 64'(mem.req_valid), 64'd1);
      cyc();
    end
    chk("tmo_drop", 64'(mem.req_valid), 64'd0);
    m_tmo = 1;
    mem.rsp_valid = 1; mem.rsp_rdata = 32'hFFFF0000; cyc(); mem.rsp_valid = 0;
    cap_chk("tmo_cap");
`else
    for (int k = 0; k < 2 * TMO; k++) begin
      chk("notmo_high", 64'(mem.req_valid), 64'd1);
      cyc();
    end
    mem.req_ready = 1; cyc(); mem.req_ready = 0;
    mem.rsp_valid = 1; mem.rsp_rdata = 32'h13572468; cyc(); mem.rsp_valid = 0;
    m_rdata = 32'h13572468; m_rdv = 1;
    cap_chk("notmo_cap");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
